clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Parametrised integer clock divider. Divides i_ref_clk by a runtime ratio
//   2..2^RATIO_WD-1 and adds selectable odd-ratio duty skew, a divided-clock
//   edge tick, and glitch-free ratio/enable updates at period boundaries.
//   Sits in the clock-generation path and feeds peripheral clocks (UART etc.).
// PARAMETERS
//   RATIO_WD      8   width of i_div_ratio / o_ratio_act (max ratio 2^RATIO_WD-1)
// PORTS
//   i_ref_clk     in   1         reference clock, all logic on posedge
//   i_rst_n       in   1         asynchronous active-low reset
//   i_clk_en      in   1         1 = divide, 0 = bypass (sampled at boundaries)
//   i_div_ratio   in   RATIO_WD  requested ratio N; N<2 = bypass
//   i_odd_hi_long in   1         odd N: 1 = high phase longer, 0 = low phase longer
//   o_div_clk     out  1         divided clock, or i_ref_clk in bypass
//   o_div_tick    out  1         1-ref-cycle pulse marking each o_div_clk rise (divide mode)
//   o_ratio_act   out  RATIO_WD  ratio currently in force (0 in bypass)
// BEHAVIOUR
//   - Registers: div_q, cnt[RATIO_WD-1:0], r_act[RATIO_WD-1:0], en_act, tick_q.
//   - Reset (async, i_rst_n=0): div_q=0, cnt=0, r_act=0, en_act=0, tick_q=0;
//     o_div_clk = i_ref_clk (bypass), o_div_tick=0, o_ratio_act=0.
//   - o_div_clk = en_act ? div_q : i_ref_clk (single output mux, no other comb logic).
//   - Phase lengths for active N: even -> H=L=N/2. Odd -> short=floor(N/2),
//     long=ceil(N/2); H=long,L=short if i_odd_hi_long=1 else H=short,L=long.
//     i_odd_hi_long is latched together with r_act (shadow, not live).
//   - States: BYPASS (en_act=0), HIGH (en_act=1,div_q=1), LOW (en_act=1,div_q=0).
//   - BYPASS -> HIGH: first posedge with i_clk_en=1 and i_div_ratio>=2:
//     r_act<=i_div_ratio, div_q<=1, cnt<=1, en_act<=1, tick_q<=1. No runt: ref
//     clk is high just after that edge, div_q takes over high.
//   - HIGH: cnt increments each edge; at edge with cnt==H -> LOW, div_q<=0, cnt<=1.
//   - LOW: cnt increments; at edge with cnt==L = period boundary:
//       if i_clk_en=1 and i_div_ratio>=2 -> HIGH, reload r_act/odd_hi_long,
//         div_q<=1, cnt<=1, tick_q<=1;
//       else -> BYPASS, en_act<=0, r_act<=0, div_q<=0.
//   - Ratio or enable changes mid-period never shorten/lengthen the current
//     period; they apply only at the next boundary. Output period always = r_act.
//   - tick_q asserted exactly one ref cycle, coincident with div_q high start;
//     0 in BYPASS.
//   - Max N=2^RATIO_WD-1: long phase = 2^(RATIO_WD-1) fits cnt; no wrap.
//   - Reset mid-period: immediate async return to reset values; after release,
//     re-entry per BYPASS -> HIGH rule.
// TESTING
//   1 N=2, en=1 -> o_div_clk period 20 ns (10 ns ref), 10 ns high, tick every 20 ns.
//   2 N=5, odd_hi_long=0 -> high 2 ref cycles, low 3; odd_hi_long=1 -> high 3, low 2.
//   3 N=0, 1, or en=0 -> o_div_clk identical to i_ref_clk, tick=0, o_ratio_act=0.
//   4 N=4 running, change to 6 mid-HIGH -> current period stays 4 cycles, next 6;
//     o_ratio_act switches at the boundary edge.
//   5 en 1->0 mid-HIGH with N=8 -> full 8-cycle period completes, then bypass,
//     no pulse shorter than 1 ref half-period on o_div_clk.
//   6 N=255 (RATIO_WD=8) -> high 127 / low 128; assert i_rst_n=0 mid-LOW ->
//     outputs at reset values immediately; release -> restart in HIGH at next edge.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with odd-ratio duty skew, rise tick and boundary-only ratio/enable updates.
// Latency: ratio/enable take effect at the next period boundary (or next edge from bypass); no backpressure.
module clk_div_prog #(
  parameter int RATIO_WD = 8
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  input  logic                i_odd_hi_long,
  output logic                o_div_clk,
  output logic                o_div_tick,
  output logic [RATIO_WD-1:0] o_ratio_act
);

  typedef enum logic [1:0] {
    ST_BYPASS,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t              state_q;
  logic                div_q;
  logic                en_act;
  logic                tick_q;
  logic                odd_hi_q;
  logic [RATIO_WD-1:0] cnt;
  logic [RATIO_WD-1:0] r_act;

  logic [RATIO_WD-1:0] ph_short;
  logic [RATIO_WD-1:0] ph_long;
  logic [RATIO_WD-1:0] ph_hi;
  logic [RATIO_WD-1:0] ph_lo;
  logic                start_ok;

  // Phase lengths come only from the shadowed ratio/skew, so live input changes cannot disturb a period.
  assign ph_short = r_act >> 1;
  assign ph_long  = ph_short + {{(RATIO_WD-1){1'b0}}, r_act[0]};
  assign ph_hi    = odd_hi_q ? ph_long  : ph_short;
  assign ph_lo    = odd_hi_q ? ph_short : ph_long;
  assign start_ok = i_clk_en && (i_div_ratio >= RATIO_WD'(2));

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_BYPASS;
      div_q    <= 1'b0;
      en_act   <= 1'b0;
      tick_q   <= 1'b0;
      odd_hi_q <= 1'b0;
      cnt      <= '0;
      r_act    <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_BYPASS: begin
          // Ref clock is high right after this edge, so div_q taking over high leaves no runt.
          if (start_ok) begin
            state_q  <= ST_HIGH;
            r_act    <= i_div_ratio;
            odd_hi_q <= i_odd_hi_long;
            div_q    <= 1'b1;
            cnt      <= RATIO_WD'(1);
            en_act   <= 1'b1;
            tick_q   <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt == ph_hi) begin
            state_q <= ST_LOW;
            div_q   <= 1'b0;
            cnt     <= RATIO_WD'(1);
          end else begin
            cnt <= cnt + RATIO_WD'(1);
          end
        end
        ST_LOW: begin
          if (cnt == ph_lo) begin
            if (start_ok) begin
              state_q  <= ST_HIGH;
              r_act    <= i_div_ratio;
              odd_hi_q <= i_odd_hi_long;
              div_q    <= 1'b1;
              cnt      <= RATIO_WD'(1);
              tick_q   <= 1'b1;
            end else begin
              state_q  <= ST_BYPASS;
              en_act   <= 1'b0;
              r_act    <= '0;
              odd_hi_q <= 1'b0;
              div_q    <= 1'b0;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + RATIO_WD'(1);
          end
        end
        default: begin
          state_q <= ST_BYPASS;
          en_act  <= 1'b0;
          div_q   <= 1'b0;
          r_act   <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign o_div_clk   = en_act ? div_q : i_ref_clk;
  assign o_div_tick  = tick_q;
  assign o_ratio_act = r_act;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: position-in-period model checked every half cycle, plus directed phase/period measurements.
module tb_clk_div_prog;
  localparam int W = 8;

  logic         ref_clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic [W-1:0] div_ratio;
  logic         odd_hi_long;
  logic         div_clk;
  logic         div_tick;
  logic [W-1:0] ratio_act;

  int checks = 0;
  int passes = 0;

  always #5 ref_clk = ~ref_clk;

  clk_div_prog #(.RATIO_WD(W)) dut (
    .i_ref_clk    (ref_clk),
    .i_rst_n      (rst_n),
    .i_clk_en     (clk_en),
    .i_div_ratio  (div_ratio),
    .i_odd_hi_long(odd_hi_long),
    .o_div_clk    (div_clk),
    .o_div_tick   (div_tick),
    .o_ratio_act  (ratio_act)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Model: divide mode is a position 0..N-1 within the period; output is high while pos < H.
  bit m_div;
  int m_n, m_h, m_pos;

  function automatic int high_len(input int n, input bit hi_long);
    if (n % 2 == 0) return n / 2;
    return hi_long ? (n + 1) / 2 : n / 2;
  endfunction

  function automatic void model_reset();
    m_div = 0; m_n = 0; m_h = 0; m_pos = 0;
  endfunction

  function automatic void model_step();
    bit want = clk_en && (int'(div_ratio) >= 2);
    if (m_div) begin
      m_pos++;
      if (m_pos < m_n) return;
      if (!want) begin model_reset(); return; end
    end else if (!want) return;
    m_div = 1; m_n = div_ratio; m_h = high_len(m_n, odd_hi_long); m_pos = 0;
  endfunction

  function automatic void compare(input bit ref_phase);
    if (!rst_n) model_reset();
    check("m_div_clk", div_clk, m_div ? int'(m_pos < m_h) : int'(ref_phase));
    check("m_tick", div_tick, int'(m_div && m_pos == 0));
    check("m_ratio_act", ratio_act, m_div ? m_n : 0);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge ref_clk);
      if (!rst_n) model_reset();
      else model_step();
      #1 compare(1'b1);
      @(negedge ref_clk);
      #1 compare(1'b0);
    end
  end

  task automatic wait_tick();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge ref_clk); #1;
      if (div_tick) begin ok = 1; break; end
    end
    check("tick_seen", ok, 1);
  endtask

  // Skips one period to settle, then measures high and low phase in ref cycles.
  task automatic measure(input string nm, input int exp_hi, input int exp_lo);
    int hi, lo;
    wait_tick();
    wait_tick();
    hi = 1;
    for (int i = 0; i < 600; i++) begin
      @(posedge ref_clk); #1;
      if (div_clk) hi++; else break;
    end
    lo = 1;
    for (int i = 0; i < 600; i++) begin
      @(posedge ref_clk); #1;
      if (!div_clk) lo++; else break;
    end
    check({nm, "_high"}, hi, exp_hi);
    check({nm, "_low"}, lo, exp_lo);
  endtask

  task automatic tick_gap(input string nm, input int exp_gap, input int exp_prev, input int exp_new);
    int g = 0;
    int prev = ratio_act;
    for (int i = 0; i < 600; i++) begin
      prev = ratio_act;
      @(posedge ref_clk); #1;
      g++;
      if (div_tick) break;
    end
    check({nm, "_gap"}, g, exp_gap);
    check({nm, "_ratio_before"}, prev, exp_prev);
    check({nm, "_ratio_after"}, ratio_act, exp_new);
  endtask

  initial begin
    int g;
    rst_n = 0; clk_en = 0; div_ratio = '0; odd_hi_long = 0;
    #2;
    check("rst_ratio_act", ratio_act, 0);
    check("rst_tick", div_tick, 0);
    check("rst_div_clk_follows_ref", div_clk, ref_clk);
    repeat (2) @(negedge ref_clk);
    rst_n = 1;

    // Bypass cases: N=0, N=1, en=0
    clk_en = 1; div_ratio = 8'd0;
    repeat (4) @(negedge ref_clk);
    div_ratio = 8'd1;
    repeat (4) @(negedge ref_clk);
    clk_en = 0; div_ratio = 8'd5;
    repeat (4) @(negedge ref_clk);
    check("bypass_ratio_act", ratio_act, 0);
    check("bypass_tick", div_tick, 0);

    clk_en = 1; div_ratio = 8'd2;
    measure("n2", 1, 1);

    @(negedge ref_clk); div_ratio = 8'd5; odd_hi_long = 0;
    measure("n5_lo_long", 2, 3);
    @(negedge ref_clk); odd_hi_long = 1;
    measure("n5_hi_long", 3, 2);

    @(negedge ref_clk); div_ratio = 8'd4; odd_hi_long = 0;
    measure("n4", 2, 2);
    @(negedge ref_clk); div_ratio = 8'd6;
    tick_gap("n4_to_6", 4, 4, 6);
    tick_gap("n6", 6, 6, 6);

    @(negedge ref_clk); div_ratio = 8'd8;
    measure("n8", 4, 4);
    @(negedge ref_clk); clk_en = 0;
    g = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ref_clk); #1;
      g++;
      if (ratio_act == 0) break;
    end
    check("en_off_period", g, 8);
    repeat (4) @(negedge ref_clk);

    clk_en = 1; div_ratio = 8'd255; odd_hi_long = 0;
    measure("n255", 127, 128);
    repeat (150) @(negedge ref_clk);
    rst_n = 0;
    #1;
    check("midlow_rst_ratio_act", ratio_act, 0);
    check("midlow_rst_tick", div_tick, 0);
    check("midlow_rst_div_clk", div_clk, 0);
    @(negedge ref_clk); rst_n = 1;
    @(posedge ref_clk); #1;
    check("restart_tick", div_tick, 1);
    check("restart_ratio_act", ratio_act, 255);
    check("restart_div_clk", div_clk, 1);
    repeat (4) @(negedge ref_clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
